// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller; sole driver of the mem array while testing.
// Define MBIST_FAIL_LOG_EN to build the first-failure capture (fail_add/fail_exp/fail_act).
module mbist_march_ctrl #(
    parameter int word_size    = 8,
    parameter int address_bits = 4,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic [2:0]              elem,
    output logic                    enable,
    output logic                    RW,
    output logic [address_bits-1:0] add,
    output logic [word_size-1:0]    data_w,
    input  logic [word_size-1:0]    data_r,
    output logic [address_bits-1:0] fail_add,
    output logic [word_size-1:0]    fail_exp,
    output logic [word_size-1:0]    fail_act
);

    // CMP and NEXT are resolved on the edge that ends the last RWAIT or WRITE cycle, so they cost no cycles.
    typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, CMP, NEXT, DONE} state_t;

    localparam logic [address_bits-1:0] ADD_FIRST = '0;
    localparam logic [address_bits-1:0] ADD_LAST  = '1;
    localparam logic [address_bits-1:0] ADD_ONE   = address_bits'(1);
    localparam logic [2:0]              WAIT_LAST = 3'(RD_LAT - 1);

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic [2:0]              elem_inc;
    logic [address_bits-1:0] add_q, add_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic                    enable_q, enable_d;
    logic                    rw_q, rw_d;
    logic [word_size-1:0]    data_w_q, data_w_d;

    logic                    descending;
    logic                    terminal;
    logic                    cmp_now;
    logic                    mismatch;
    logic                    next_addr;
    logic [word_size-1:0]    exp_word;

    assign descending = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign terminal   = descending ? (add_q == ADD_FIRST) : (add_q == ADD_LAST);
    assign elem_inc   = elem_q + 3'd1;
    assign exp_word   = {word_size{(elem_q == 3'd2) || (elem_q == 3'd4)}};
    assign cmp_now    = (state_q == RWAIT) && (cnt_q == 3'd0);
    assign mismatch   = cmp_now && (data_r != exp_word);

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        add_d     = add_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q | mismatch;
        next_addr = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WRITE;
                    elem_d  = 3'd0;
                    add_d   = ADD_FIRST;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            WRITE: next_addr = 1'b1;
            READ: begin
                state_d = RWAIT;
                cnt_d   = WAIT_LAST;
            end
            RWAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (elem_q == 3'd5) begin
                    next_addr = 1'b1;
                end else begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (next_addr) begin
            if (!terminal) begin
                add_d   = descending ? (add_q - ADD_ONE) : (add_q + ADD_ONE);
                state_d = (elem_q == 3'd0) ? WRITE : READ;
            end else if (elem_q == 3'd5) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = ~fail_d;
            end else begin
                elem_d  = elem_inc;
                add_d   = ((elem_inc == 3'd3) || (elem_inc == 3'd4)) ? ADD_LAST : ADD_FIRST;
                state_d = READ;
            end
        end

        enable_d = (state_d == WRITE) || (state_d == READ);
        rw_d     = (state_d == READ);
        data_w_d = (state_d == WRITE) ? {word_size{elem_d[0]}} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            elem_q   <= '0;
            add_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            enable_q <= 1'b0;
            rw_q     <= 1'b0;
            data_w_q <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            add_q    <= add_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            enable_q <= enable_d;
            rw_q     <= rw_d;
            data_w_q <= data_w_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign pass   = pass_q;
    assign fail   = fail_q;
    assign elem   = elem_q;
    assign enable = enable_q;
    assign RW     = rw_q;
    assign add    = add_q;
    assign data_w = data_w_q;

`ifdef MBIST_FAIL_LOG_EN
    logic                    accept;
    logic [address_bits-1:0] fail_add_q, fail_add_d;
    logic [word_size-1:0]    fail_exp_q, fail_exp_d;
    logic [word_size-1:0]    fail_act_q, fail_act_d;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    // Only the first mismatch of a run is kept; fail_q is still low at that compare.
    always_comb begin
        fail_add_d = fail_add_q;
        fail_exp_d = fail_exp_q;
        fail_act_d = fail_act_q;
        if (accept) begin
            fail_add_d = '0;
            fail_exp_d = '0;
            fail_act_d = '0;
        end else if (mismatch && !fail_q) begin
            fail_add_d = add_q;
            fail_exp_d = exp_word;
            fail_act_d = data_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_add_q <= '0;
            fail_exp_q <= '0;
            fail_act_q <= '0;
        end else begin
            fail_add_q <= fail_add_d;
            fail_exp_q <= fail_exp_d;
            fail_act_q <= fail_act_d;
        end
    end

    assign fail_add = fail_add_q;
    assign fail_exp = fail_exp_q;
    assign fail_act = fail_act_q;
`else
    assign fail_add = '0;
    assign fail_exp = '0;
    assign fail_act = '0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: RD_LAT=1 instance (full op stream, faults, reset, restart)
// and RD_LAT=3 instance (run length and pass).
`timescale 1ns/1ps
module tb_mbist_march_ctrl;
    localparam int N = 16;

    typedef struct packed {
        logic       rw;
        logic [3:0] add;
        logic [7:0] data;
    } op_t;

    typedef struct packed {
        logic [15:0] lat;
        logic        pass;
        logic        fail;
        logic [3:0]  fadd;
        logic [7:0]  fexp;
        logic [7:0]  fact;
    } run_t;

    logic clk = 1'b0;
    logic rst;
    logic stuck_en;
    always #5 clk = ~clk;

    logic       start_a, busy_a, done_a, pass_a, fail_a, en_a, rw_a;
    logic [2:0] elem_a;
    logic [3:0] add_a, fadd_a;
    logic [7:0] dw_a, dr_a, fexp_a, fact_a;

    logic       start_b, busy_b, done_b, pass_b, fail_b, en_b, rw_b;
    logic [2:0] elem_b;
    logic [3:0] add_b, fadd_b;
    logic [7:0] dw_b, dr_b, fexp_b, fact_b;

    mbist_march_ctrl #(.word_size(8), .address_bits(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .elem(elem_a), .enable(en_a), .RW(rw_a),
        .add(add_a), .data_w(dw_a), .data_r(dr_a),
        .fail_add(fadd_a), .fail_exp(fexp_a), .fail_act(fact_a)
    );

    mbist_march_ctrl #(.word_size(8), .address_bits(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .elem(elem_b), .enable(en_b), .RW(rw_b),
        .add(add_b), .data_w(dw_b), .data_r(dr_b),
        .fail_add(fadd_b), .fail_exp(fexp_b), .fail_act(fact_b)
    );

    // Array A: one-cycle read latency, optional stuck bit 8'h10 at address 5.
    logic [7:0] mem_a [N];
    always @(posedge clk) begin
        if (en_a) begin
            if (rw_a) dr_a <= mem_a[add_a] | ((stuck_en && add_a == 4'd5) ? 8'h10 : 8'h00);
            else      mem_a[add_a] <= dw_a;
        end
    end

    // Array B: three-stage read pipeline.
    logic [7:0] mem_b [N];
    logic [7:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_b[0] <= (en_b && rw_b) ? mem_b[add_b] : 8'h00;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (en_b && !rw_b) mem_b[add_b] <= dw_b;
    end
    assign dr_b = pipe_b[2];

    op_t  op_q[$];
    run_t run_qa[$];
    run_t run_qb[$];
    int   checks = 0;
    int   passes = 0;
    int   edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endtask

    task automatic reportExtra(input string name, input logic [31:0] act);
        checks++;
        $display("[TB] FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    task automatic pushOps();
        logic [3:0] a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? 4'(N - 1 - i) : 4'(i);
                if (e >= 1) op_q.push_back(op_t'{1'b1, a, 8'h00});
                if (e <= 4) op_q.push_back(op_t'{1'b0, a, (e % 2 == 1) ? 8'hFF : 8'h00});
            end
        end
    endtask

    task automatic applyStimulus(input bit use_b, input bit fault);
        run_t r;
        r.lat  = use_b ? 16'd400 : 16'd240;
        r.pass = !fault;
        r.fail = fault;
`ifdef MBIST_FAIL_LOG_EN
        r.fadd = fault ? 4'd5 : 4'd0;
        r.fexp = 8'h00;
        r.fact = fault ? 8'h10 : 8'h00;
`else
        r.fadd = 4'd0;
        r.fexp = 8'h00;
        r.fact = 8'h00;
`endif
        @(negedge clk);
        if (use_b) begin
            run_qb.push_back(r);
            start_b = 1'b1;
        end else begin
            run_qa.push_back(r);
            pushOps();
            start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDone(input bit use_b, input int limit);
        int n = 0;
        while (!(use_b ? done_b : done_a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput("done_timeout", use_b ? done_b : done_a, 1);
        @(negedge clk);
    endtask

    initial begin : mon_a
        int   rise_a;
        logic busy_prev;
        logic done_prev;
        op_t  o;
        run_t r;
        rise_a = 0;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (en_a) begin
                if (op_q.size() == 0) reportExtra("op_extra", {rw_a, add_a, dw_a});
                else begin
                    o = op_q.pop_front();
                    checkOutput("op_stream", {rw_a, add_a, dw_a}, o);
                end
            end
            if (busy_a && !busy_prev) begin
                rise_a = edge_n;
                checkOutput("busy_after_start", start_a, 1);
            end
            if (done_a && !done_prev) begin
                if (run_qa.size() == 0) reportExtra("done_a_extra", done_a);
                else begin
                    r = run_qa.pop_front();
                    checkOutput("lat_a", edge_n - rise_a, r.lat);
                    checkOutput("pass_a", pass_a, r.pass);
                    checkOutput("fail_a", fail_a, r.fail);
                    checkOutput("busy_a_end", busy_a, 0);
                    checkOutput("elem_a_end", elem_a, 5);
                    checkOutput("fail_add_a", fadd_a, r.fadd);
                    checkOutput("fail_exp_a", fexp_a, r.fexp);
                    checkOutput("fail_act_a", fact_a, r.fact);
                end
            end
            busy_prev = busy_a;
            done_prev = done_a;
        end
    end

    initial begin : mon_b
        int   rise_b;
        logic busy_prev;
        logic done_prev;
        run_t r;
        rise_b = 0;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_b && !busy_prev) rise_b = edge_n;
            if (done_b && !done_prev) begin
                if (run_qb.size() == 0) reportExtra("done_b_extra", done_b);
                else begin
                    r = run_qb.pop_front();
                    checkOutput("lat_b", edge_n - rise_b, r.lat);
                    checkOutput("pass_b", pass_b, r.pass);
                    checkOutput("fail_b", fail_b, r.fail);
                end
            end
            busy_prev = busy_b;
            done_prev = done_b;
        end
    end

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        stuck_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_pass", pass_a, 0);
        checkOutput("rst_fail", fail_a, 0);
        checkOutput("rst_enable", en_a, 0);
        checkOutput("rst_rw", rw_a, 0);
        checkOutput("rst_add", add_a, 0);
        checkOutput("rst_data_w", dw_a, 0);
        checkOutput("rst_elem", elem_a, 0);
        checkOutput("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDone(1'b0, 400);
        repeat (5) @(negedge clk);
        checkOutput("done_hold", done_a, 1);
        checkOutput("pass_hold", pass_a, 1);
        waitDone(1'b1, 600);

        applyStimulus(1'b0, 1'b0);
        repeat (48) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_enable", en_a, 0);
        checkOutput("abort_busy", busy_a, 0);
        checkOutput("abort_done", done_a, 0);
        checkOutput("abort_fail", fail_a, 0);
        checkOutput("abort_add", add_a, 0);
        op_q.delete();
        run_qa.delete();
        @(negedge clk);

        applyStimulus(1'b0, 1'b0);
        waitDone(1'b0, 400);

        applyStimulus(1'b0, 1'b0);
        repeat (30) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        waitDone(1'b0, 400);

        stuck_en = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitDone(1'b0, 400);
        stuck_en = 1'b0;

        checkOutput("ops_left", op_q.size(), 0);
        checkOutput("runs_left_a", run_qa.size(), 0);
        checkOutput("runs_left_b", run_qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
